// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types, constants and register-match helper for the hazard unit
package hazard_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  typedef enum logic [0:0] {IDLE, MDU_WAIT} hazard_state_e;

  // x0 and sources the instruction does not read can never create a dependency
  function automatic logic src_hits(input logic [REG_ADDR_W-1:0] src,
                                    input logic                  used,
                                    input logic [REG_ADDR_W-1:0] rd);
    return used && (src != REG_ZERO) && (src == rd);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use and branch-dependency detection for the ID stage
module hazard_detect
  import hazard_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] rs1_address_id_i,
  input  logic                  rs1_used_id_i,
  input  logic [REG_ADDR_W-1:0] rs2_address_id_i,
  input  logic                  rs2_used_id_i,
  input  logic [REG_ADDR_W-1:0] rs3_address_id_i,
  input  logic                  rs3_used_id_i,
  input  logic                  branch_id_i,
  input  logic                  rd_we_ex_i,
  input  logic                  mem_to_reg_ex_i,
  input  logic [REG_ADDR_W-1:0] rd_address_ex_i,
  input  logic                  rd_we_mem_i,
  input  logic                  mem_to_reg_mem_i,
  input  logic [REG_ADDR_W-1:0] rd_address_mem_i,
  output logic                  stall_o
);

  logic rs1_ex, rs2_ex, rs3_ex;
  logic rs1_mem, rs2_mem;
  logic load_use, branch_ex, branch_mem;

  assign rs1_ex  = src_hits(rs1_address_id_i, rs1_used_id_i, rd_address_ex_i);
  assign rs2_ex  = src_hits(rs2_address_id_i, rs2_used_id_i, rd_address_ex_i);
  assign rs3_ex  = src_hits(rs3_address_id_i, rs3_used_id_i, rd_address_ex_i);
  assign rs1_mem = src_hits(rs1_address_id_i, rs1_used_id_i, rd_address_mem_i);
  assign rs2_mem = src_hits(rs2_address_id_i, rs2_used_id_i, rd_address_mem_i);

  assign load_use = mem_to_reg_ex_i & rd_we_ex_i & (rs1_ex | rs2_ex | rs3_ex);

  // Branches compare in ID, so any EX result and any load still in MEM is too late to forward
  assign branch_ex  = branch_id_i & rd_we_ex_i & (rs1_ex | rs2_ex);
  assign branch_mem = branch_id_i & mem_to_reg_mem_i & rd_we_mem_i & (rs1_mem | rs2_mem);

  assign stall_o = load_use | branch_ex | branch_mem;

endmodule

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - stall/flush FSM with MDU watchdog; HAZARD_PERF_CNT_EN adds a stall-cycle counter
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned MDU_MAX_CYCLES = 34,
  parameter int unsigned CNT_W          = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] rs1_address_id_i,
  input  logic                  rs1_used_id_i,
  input  logic [REG_ADDR_W-1:0] rs2_address_id_i,
  input  logic                  rs2_used_id_i,
  input  logic [REG_ADDR_W-1:0] rs3_address_id_i,
  input  logic                  rs3_used_id_i,
  input  logic                  branch_id_i,
  input  logic                  rd_we_ex_i,
  input  logic                  mem_to_reg_ex_i,
  input  logic [REG_ADDR_W-1:0] rd_address_ex_i,
  input  logic                  rd_we_mem_i,
  input  logic                  mem_to_reg_mem_i,
  input  logic [REG_ADDR_W-1:0] rd_address_mem_i,
  input  logic                  pc_redirect_i,
  input  logic                  mdu_start_ex_i,
  input  logic                  mdu_done_i,
  output logic                  pc_en_o,
  output logic                  if_id_en_o,
  output logic                  id_ex_en_o,
  output logic                  if_id_flush_o,
  output logic                  id_ex_flush_o,
  output logic                  ex_mem_flush_o,
  output logic                  mdu_timeout_o,
  output logic [CNT_W-1:0]      stall_cycles_o
);

  localparam int unsigned WDOG_W = $clog2(MDU_MAX_CYCLES + 1);

  hazard_state_e     state_q, state_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              timeout_q, timeout_d;
  logic              hazard_stall;
  logic              wdog_expire;
  logic              pc_en, if_id_en, id_ex_en;
  logic              if_id_flush, id_ex_flush, ex_mem_flush;

  hazard_detect u_detect (
    .rs1_address_id_i (rs1_address_id_i),
    .rs1_used_id_i    (rs1_used_id_i),
    .rs2_address_id_i (rs2_address_id_i),
    .rs2_used_id_i    (rs2_used_id_i),
    .rs3_address_id_i (rs3_address_id_i),
    .rs3_used_id_i    (rs3_used_id_i),
    .branch_id_i      (branch_id_i),
    .rd_we_ex_i       (rd_we_ex_i),
    .mem_to_reg_ex_i  (mem_to_reg_ex_i),
    .rd_address_ex_i  (rd_address_ex_i),
    .rd_we_mem_i      (rd_we_mem_i),
    .mem_to_reg_mem_i (mem_to_reg_mem_i),
    .rd_address_mem_i (rd_address_mem_i),
    .stall_o          (hazard_stall)
  );

  always_comb begin
    state_d      = state_q;
    wdog_d       = wdog_q;
    timeout_d    = timeout_q;
    wdog_expire  = 1'b0;
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    case (state_q)
      IDLE: begin
        // A stalled ID instruction will see the redirect again once it is released
        if (hazard_stall) begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
        end else if (pc_redirect_i) begin
          if_id_flush = 1'b1;
        end
        if (mdu_start_ex_i) begin
          state_d = MDU_WAIT;
          wdog_d  = WDOG_W'(1);
        end
      end
      MDU_WAIT: begin
        wdog_d = wdog_q + WDOG_W'(1);
        if (mdu_done_i) begin
          state_d = IDLE;
          wdog_d  = '0;
        end else if (wdog_q == WDOG_W'(MDU_MAX_CYCLES)) begin
          wdog_expire = 1'b1;
          timeout_d   = 1'b1;
          state_d     = IDLE;
          wdog_d      = '0;
        end else begin
          pc_en        = 1'b0;
          if_id_en     = 1'b0;
          id_ex_en     = 1'b0;
          ex_mem_flush = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        wdog_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
    end
  end

  // Reset forces the freeze-and-bubble pattern on the outputs without waiting for a clock
  assign pc_en_o        = rst & pc_en;
  assign if_id_en_o     = rst & if_id_en;
  assign id_ex_en_o     = rst & id_ex_en;
  assign if_id_flush_o  = ~rst | if_id_flush;
  assign id_ex_flush_o  = ~rst | id_ex_flush;
  assign ex_mem_flush_o = ~rst | ex_mem_flush;
  assign mdu_timeout_o  = rst & (timeout_q | wdog_expire);

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_en && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cycles_o = stall_cnt_q;
`else
  assign stall_cycles_o = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - directed self-checking bench for hazard_unit
module tb_hazard_unit;

  logic        clk;
  logic        rst;
  logic [4:0]  rs1_address_id_i, rs2_address_id_i, rs3_address_id_i;
  logic        rs1_used_id_i, rs2_used_id_i, rs3_used_id_i;
  logic        branch_id_i;
  logic        rd_we_ex_i, mem_to_reg_ex_i;
  logic [4:0]  rd_address_ex_i;
  logic        rd_we_mem_i, mem_to_reg_mem_i;
  logic [4:0]  rd_address_mem_i;
  logic        pc_redirect_i, mdu_start_ex_i, mdu_done_i;
  logic        pc_en_o, if_id_en_o, id_ex_en_o;
  logic        if_id_flush_o, id_ex_flush_o, ex_mem_flush_o;
  logic        mdu_timeout_o;
  logic [31:0] stall_cycles_o;

  // {pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, ex_mem_flush}
  logic [5:0]  ctl;
  localparam logic [5:0] C_RUN    = 6'b111_000;
  localparam logic [5:0] C_STALL  = 6'b001_010;
  localparam logic [5:0] C_REDIR  = 6'b111_100;
  localparam logic [5:0] C_MDU    = 6'b000_001;
  localparam logic [5:0] C_RESET  = 6'b000_111;

  int n_checks;
  int n_fail;

  assign ctl = {pc_en_o, if_id_en_o, id_ex_en_o, if_id_flush_o, id_ex_flush_o, ex_mem_flush_o};

  hazard_unit #(.MDU_MAX_CYCLES(34), .CNT_W(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .rs1_address_id_i (rs1_address_id_i),
    .rs1_used_id_i    (rs1_used_id_i),
    .rs2_address_id_i (rs2_address_id_i),
    .rs2_used_id_i    (rs2_used_id_i),
    .rs3_address_id_i (rs3_address_id_i),
    .rs3_used_id_i    (rs3_used_id_i),
    .branch_id_i      (branch_id_i),
    .rd_we_ex_i       (rd_we_ex_i),
    .mem_to_reg_ex_i  (mem_to_reg_ex_i),
    .rd_address_ex_i  (rd_address_ex_i),
    .rd_we_mem_i      (rd_we_mem_i),
    .mem_to_reg_mem_i (mem_to_reg_mem_i),
    .rd_address_mem_i (rd_address_mem_i),
    .pc_redirect_i    (pc_redirect_i),
    .mdu_start_ex_i   (mdu_start_ex_i),
    .mdu_done_i       (mdu_done_i),
    .pc_en_o          (pc_en_o),
    .if_id_en_o       (if_id_en_o),
    .id_ex_en_o       (id_ex_en_o),
    .if_id_flush_o    (if_id_flush_o),
    .id_ex_flush_o    (id_ex_flush_o),
    .ex_mem_flush_o   (ex_mem_flush_o),
    .mdu_timeout_o    (mdu_timeout_o),
    .stall_cycles_o   (stall_cycles_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    rs1_address_id_i = '0; rs2_address_id_i = '0; rs3_address_id_i = '0;
    rs1_used_id_i = 0; rs2_used_id_i = 0; rs3_used_id_i = 0;
    branch_id_i = 0; rd_we_ex_i = 0; mem_to_reg_ex_i = 0; rd_address_ex_i = '0;
    rd_we_mem_i = 0; mem_to_reg_mem_i = 0; rd_address_mem_i = '0;
    pc_redirect_i = 0; mdu_start_ex_i = 0; mdu_done_i = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if (ctl !== C_RESET || mdu_timeout_o !== 1'b0 || stall_cycles_o !== 32'd0) begin
      $display("FAIL reset_values ctl=%b timeout=%b cnt=%0d required ctl=%b timeout=0 cnt=0",
               ctl, mdu_timeout_o, stall_cycles_o, C_RESET);
      n_fail++;
    end
    @(negedge clk);
    rst = 1'b1;
    step();
    @(negedge clk);
    n_checks++;
    if (ctl !== C_RUN) begin
      $display("FAIL reset_release ctl=%b required %b", ctl, C_RUN);
      n_fail++;
    end
    step();
  endtask

  task automatic test_load_use();
    clear_inputs();
    mem_to_reg_ex_i = 1; rd_we_ex_i = 1; rd_address_ex_i = 5'd5;
    rs1_address_id_i = 5'd5; rs1_used_id_i = 1;
    rs2_address_id_i = 5'd1; rs2_used_id_i = 1;
    @(negedge clk);
    n_checks++;
    if (ctl !== C_STALL) begin
      $display("FAIL load_use_stall ctl=%b required %b", ctl, C_STALL);
      n_fail++;
    end
    step();
    rd_we_ex_i = 0; mem_to_reg_ex_i = 0; rd_address_ex_i = '0;
    rd_we_mem_i = 1; mem_to_reg_mem_i = 1; rd_address_mem_i = 5'd5;
    @(negedge clk);
    n_checks++;
    if (ctl !== C_RUN) begin
      $display("FAIL load_use_release ctl=%b required %b", ctl, C_RUN);
      n_fail++;
    end
    step();
    clear_inputs();
    mem_to_reg_ex_i = 1; rd_we_ex_i = 1; rd_address_ex_i = 5'd12;
    rs1_address_id_i = 5'd3; rs1_used_id_i = 1;
    rs3_address_id_i = 5'd12; rs3_used_id_i = 1;
    @(negedge clk);
    n_checks++;
    if (ctl !== C_STALL) begin
      $display("FAIL load_use_rs3 ctl=%b required %b", ctl, C_STALL);
      n_fail++;
    end
    step();
  endtask

  task automatic test_x0_and_unused();
    clear_inputs();
    mem_to_reg_ex_i = 1; rd_we_ex_i = 1; rd_address_ex_i = 5'd0;
    rs1_address_id_i = 5'd0; rs1_used_id_i = 1;
    @(negedge clk);
    n_checks++;
    if (ctl !== C_RUN) begin
      $display("FAIL x0_no_hazard ctl=%b required %b", ctl, C_RUN);
      n_fail++;
    end
    step();
    clear_inputs();
    mem_to_reg_ex_i = 1; rd_we_ex_i = 1; rd_address_ex_i = 5'd7;
    rs2_address_id_i = 5'd7; rs2_used_id_i = 0;
    @(negedge clk);
    n_checks++;
    if (ctl !== C_RUN) begin
      $display("FAIL unused_rs2_no_hazard ctl=%b required %b", ctl, C_RUN);
      n_fail++;
    end
    step();
    rs2_used_id_i = 1;
    @(negedge clk);
    n_checks++;
    if (ctl !== C_STALL) begin
      $display("FAIL used_rs2_hazard ctl=%b required %b", ctl, C_STALL);
      n_fail++;
    end
    step();
    // Non-load EX writer feeding a non-branch is left to forwarding
    clear_inputs();
    rd_we_ex_i = 1; rd_address_ex_i = 5'd9;
    rs1_address_id_i = 5'd9; rs1_used_id_i = 1;
    @(negedge clk);
    n_checks++;
    if (ctl !== C_RUN) begin
      $display("FAIL alu_forwardable ctl=%b required %b", ctl, C_RUN);
      n_fail++;
    end
    step();
  endtask

  task automatic test_branch();
    clear_inputs();
    branch_id_i = 1;
    rs1_address_id_i = 5'd8; rs1_used_id_i = 1;
    rs2_address_id_i = 5'd9; rs2_used_id_i = 1;
    mem_to_reg_ex_i = 1; rd_we_ex_i = 1; rd_address_ex_i = 5'd8;
    @(negedge clk);
    n_checks++;
    if (ctl !== C_STALL) begin
      $display("FAIL branch_load_cycle1 ctl=%b required %b", ctl, C_STALL);
      n_fail++;
    end
    step();
    mem_to_reg_ex_i = 0; rd_we_ex_i = 0; rd_address_ex_i = '0;
    mem_to_reg_mem_i = 1; rd_we_mem_i = 1; rd_address_mem_i = 5'd8;
    @(negedge clk);
    n_checks++;
    if (ctl !== C_STALL) begin
      $display("FAIL branch_load_cycle2 ctl=%b required %b", ctl, C_STALL);
      n_fail++;
    end
    step();
    mem_to_reg_mem_i = 0; rd_we_mem_i = 0; rd_address_mem_i = '0;
    @(negedge clk);
    n_checks++;
    if (ctl !== C_RUN) begin
      $display("FAIL branch_load_release ctl=%b required %b", ctl, C_RUN);
      n_fail++;
    end
    step();
    rd_we_ex_i = 1; rd_address_ex_i = 5'd9;
    @(negedge clk);
    n_checks++;
    if (ctl !== C_STALL) begin
      $display("FAIL branch_alu_ex ctl=%b required %b", ctl, C_STALL);
      n_fail++;
    end
    step();
    rd_we_ex_i = 0; rd_address_ex_i = '0;
    rd_we_mem_i = 1; rd_address_mem_i = 5'd9;
    @(negedge clk);
    n_checks++;
    if (ctl !== C_RUN) begin
      $display("FAIL branch_alu_mem ctl=%b required %b", ctl, C_RUN);
      n_fail++;
    end
    step();
  endtask

  task automatic test_redirect();
    clear_inputs();
    pc_redirect_i = 1;
    @(negedge clk);
    n_checks++;
    if (ctl !== C_REDIR) begin
      $display("FAIL redirect_flush ctl=%b required %b", ctl, C_REDIR);
      n_fail++;
    end
    step();
    mem_to_reg_ex_i = 1; rd_we_ex_i = 1; rd_address_ex_i = 5'd4;
    rs1_address_id_i = 5'd4; rs1_used_id_i = 1;
    @(negedge clk);
    n_checks++;
    if (ctl !== C_STALL) begin
      $display("FAIL stall_over_redirect ctl=%b required %b", ctl, C_STALL);
      n_fail++;
    end
    step();
  endtask

  task automatic test_mdu_done();
    clear_inputs();
    mdu_start_ex_i = 1;
    @(negedge clk);
    n_checks++;
    if (ctl !== C_RUN) begin
      $display("FAIL mdu_start_cycle ctl=%b required %b", ctl, C_RUN);
      n_fail++;
    end
    step();
    mdu_start_ex_i = 0;
    // ID hazards and redirect are presented during the wait and must be ignored
    mem_to_reg_ex_i = 1; rd_we_ex_i = 1; rd_address_ex_i = 5'd6;
    rs1_address_id_i = 5'd6; rs1_used_id_i = 1; pc_redirect_i = 1;
    for (int i = 1; i <= 33; i++) begin
      @(negedge clk);
      n_checks++;
      if (ctl !== C_MDU || mdu_timeout_o !== 1'b0) begin
        $display("FAIL mdu_wait_%0d ctl=%b timeout=%b required ctl=%b timeout=0",
                 i, ctl, mdu_timeout_o, C_MDU);
        n_fail++;
      end
      step();
    end
    clear_inputs();
    mdu_done_i = 1;
    @(negedge clk);
    n_checks++;
    if (ctl !== C_RUN || mdu_timeout_o !== 1'b0) begin
      $display("FAIL mdu_done_release ctl=%b timeout=%b required ctl=%b timeout=0",
               ctl, mdu_timeout_o, C_RUN);
      n_fail++;
    end
    step();
    mdu_done_i = 0;
    @(negedge clk);
    n_checks++;
    if (ctl !== C_RUN) begin
      $display("FAIL mdu_back_to_idle ctl=%b required %b", ctl, C_RUN);
      n_fail++;
    end
    step();
  endtask

  task automatic test_mdu_timeout();
    clear_inputs();
    mdu_start_ex_i = 1;
    step();
    mdu_start_ex_i = 0;
    for (int i = 1; i <= 33; i++) begin
      // A second start while waiting must not restart the watchdog
      mdu_start_ex_i = (i == 10);
      @(negedge clk);
      n_checks++;
      if (ctl !== C_MDU || mdu_timeout_o !== 1'b0) begin
        $display("FAIL timeout_wait_%0d ctl=%b timeout=%b required ctl=%b timeout=0",
                 i, ctl, mdu_timeout_o, C_MDU);
        n_fail++;
      end
      step();
    end
    mdu_start_ex_i = 0;
    @(negedge clk);
    n_checks++;
    if (ctl !== C_RUN || mdu_timeout_o !== 1'b1) begin
      $display("FAIL timeout_at_34 ctl=%b timeout=%b required ctl=%b timeout=1",
               ctl, mdu_timeout_o, C_RUN);
      n_fail++;
    end
    step();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (ctl !== C_RUN || mdu_timeout_o !== 1'b1) begin
        $display("FAIL timeout_sticky_%0d ctl=%b timeout=%b required ctl=%b timeout=1",
                 i, ctl, mdu_timeout_o, C_RUN);
        n_fail++;
      end
      step();
    end
  endtask

  task automatic test_reset_mid_mdu();
    logic [31:0] exp_cnt;
    clear_inputs();
    mdu_start_ex_i = 1;
    step();
    mdu_start_ex_i = 0;
    repeat (5) step();
    @(negedge clk);
    n_checks++;
    if (ctl !== C_MDU || mdu_timeout_o !== 1'b1) begin
      $display("FAIL pre_reset_wait ctl=%b timeout=%b required ctl=%b timeout=1",
               ctl, mdu_timeout_o, C_MDU);
      n_fail++;
    end
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (ctl !== C_RESET || mdu_timeout_o !== 1'b0 || stall_cycles_o !== 32'd0) begin
      $display("FAIL async_reset ctl=%b timeout=%b cnt=%0d required ctl=%b timeout=0 cnt=0",
               ctl, mdu_timeout_o, stall_cycles_o, C_RESET);
      n_fail++;
    end
    step();
    @(negedge clk);
    rst = 1'b1;
    step();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (ctl !== C_RUN || mdu_timeout_o !== 1'b0 || stall_cycles_o !== 32'd0) begin
        $display("FAIL post_reset_idle_%0d ctl=%b timeout=%b cnt=%0d required ctl=%b timeout=0 cnt=0",
                 i, ctl, mdu_timeout_o, stall_cycles_o, C_RUN);
        n_fail++;
      end
      step();
    end
    mem_to_reg_ex_i = 1; rd_we_ex_i = 1; rd_address_ex_i = 5'd2;
    rs1_address_id_i = 5'd2; rs1_used_id_i = 1;
    step();
    clear_inputs();
`ifdef HAZARD_PERF_CNT_EN
    exp_cnt = 32'd1;
`else
    exp_cnt = 32'd0;
`endif
    @(negedge clk);
    n_checks++;
    if (stall_cycles_o !== exp_cnt) begin
      $display("FAIL stall_counter cnt=%0d required %0d", stall_cycles_o, exp_cnt);
      n_fail++;
    end
    step();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    clear_inputs();
    test_reset();
    test_load_use();
    test_x0_and_unused();
    test_branch();
    test_redirect();
    test_mdu_done();
    test_mdu_timeout();
    test_reset_mid_mdu();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL sim_time_limit reached before end of test");
    $fatal(1);
  end

endmodule
